hazard_unit: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RV32 core, sitting beside the ID stage and driving the PC, IF/ID and ID/EX pipeline-register controls. It detects load-use hazards with a configurable multi-cycle load latency, tracks outstanding long-latency (MUL/DIV) writebacks in a register scoreboard, and handles taken-branch flushes with priority over stalls. It also provides a free-running stall-cycle performance counter.

---
 rtl/hdu_pkg.sv | 14 +
 rtl/hdu_scoreboard.sv | 49 ++++
 rtl/hazard_unit.sv | 150 +++++++++++++++
 tb/tb_hazard_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdu_pkg.sv
// Shared encodings for the pipeline hazard controller: writeback selects and FSM states.
package hdu_pkg;

   localparam logic [1:0] WB_LOAD = 2'b00;
   localparam logic [1:0] WB_ALU  = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_CSR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1
   } hdu_state_t;

endpackage

// File: rtl/hdu_scoreboard.sv
// Busy-bit scoreboard for outstanding long-latency writebacks, with RAW/WAW lookup for ID.
module hdu_scoreboard
   import hdu_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ll_issue,
   input  logic [REG_ADDR_W-1:0] ll_issue_rd,
   input  logic                  ll_done,
   input  logic [REG_ADDR_W-1:0] ll_done_rd,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic                  rs1_used,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic                  rs2_used,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic                  rd_we,
   output logic                  raw_hit,
   output logic                  waw_hit
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_next;

   // Clear first so a same-cycle issue to the same register wins: the done belongs to the older op.
   always_comb begin
      busy_next = busy;
      if (ll_done)
         busy_next[ll_done_rd] = 1'b0;
      if (ll_issue && ll_issue_rd != '0)
         busy_next[ll_issue_rd] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy <= '0;
      else
         busy <= busy_next;
   end

   always_comb begin
      raw_hit = (rs1_used && rs1_addr != '0 && busy[rs1_addr]) ||
                (rs2_used && rs2_addr != '0 && busy[rs2_addr]);
      waw_hit = rd_we && busy[rd_addr];
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls with multi-cycle latency, long-latency scoreboard,
// branch flush priority and a stall-cycle counter. Define HAZARD_SCOREBOARD_EN for the per-register scoreboard.
module hazard_unit
   import hdu_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_REGS   = 32,
   parameter int LOAD_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd_addr,
   input  logic                  id_rd_we,
   input  logic                  id_ll_op,
   input  logic                  ex_valid,
   input  logic [1:0]            ex_wb_sel,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic                  ex_rd_we,
   input  logic                  ll_issue,
   input  logic [REG_ADDR_W-1:0] ll_issue_rd,
   input  logic                  ll_done,
   input  logic [REG_ADDR_W-1:0] ll_done_rd,
   input  logic                  ll_busy,
   input  logic                  branch_taken,
   output logic                  pc_hold,
   output logic                  ifid_hold,
   output logic                  idex_bubble,
   output logic                  ifid_flush,
   output logic [1:0]            hdu_state,
   output logic [31:0]           stall_cycles
);

   localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

   hdu_state_t state, state_next;
   logic [2:0] cnt, cnt_next;
   logic       rs1_hit, rs2_hit, load_use;
   logic       sb_stall;
   logic       stall;

   assign rs1_hit  = id_rs1_used && id_rs1_addr != '0 && id_rs1_addr == ex_rd_addr;
   assign rs2_hit  = id_rs2_used && id_rs2_addr != '0 && id_rs2_addr == ex_rd_addr;
   assign load_use = id_valid && ex_valid && ex_rd_we && ex_wb_sel == WB_LOAD &&
                     ex_rd_addr != '0 && (rs1_hit || rs2_hit);

`ifdef HAZARD_SCOREBOARD_EN
   logic raw_hit, waw_hit;

   hdu_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_REGS   (NUM_REGS)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .ll_issue    (ll_issue),
      .ll_issue_rd (ll_issue_rd),
      .ll_done     (ll_done),
      .ll_done_rd  (ll_done_rd),
      .rs1_addr    (id_rs1_addr),
      .rs1_used    (id_rs1_used),
      .rs2_addr    (id_rs2_addr),
      .rs2_used    (id_rs2_used),
      .rd_addr     (id_rd_addr),
      .rd_we       (id_rd_we),
      .raw_hit     (raw_hit),
      .waw_hit     (waw_hit)
   );

   assign sb_stall = id_valid && (raw_hit || waw_hit || (id_ll_op && ll_busy));
`else
   logic sb_unused;

   // Without a scoreboard, any busy long-latency unit serialises the instruction in ID.
   assign sb_stall  = id_valid && ll_busy;
   assign sb_unused = ^{ll_issue, ll_issue_rd, ll_done, ll_done_rd,
                        id_rd_addr, id_rd_we, id_ll_op, (NUM_REGS > 0)};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      if (branch_taken) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (load_use && LOAD_LAT > 1) begin
                  state_next = LOAD_WAIT;
                  cnt_next   = LAT_M1;
               end
            end
            LOAD_WAIT: begin
               if (cnt == 3'd1) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt - 3'd1;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // The EX comparison only counts in IDLE: during LOAD_WAIT a bubble occupies EX.
   always_comb begin
      stall       = 1'b0;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      hdu_state   = state;
      if (!rst) begin
         stall       = ((state == IDLE && load_use) || state == LOAD_WAIT || sb_stall) && !branch_taken;
         pc_hold     = stall;
         ifid_hold   = stall;
         idex_bubble = stall || branch_taken;
         ifid_flush  = branch_taken;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cycles <= '0;
      else if (pc_hold)
         stall_cycles <= stall_cycles + 32'd1;
   end

   ll_issue_not_stalled: assert property (@(posedge clk) disable iff (rst) !(ll_issue && stall));

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: LOAD_LAT=1 and LOAD_LAT=3 instances checked against a remaining-cycles model.
module tb_hazard_unit;
   import hdu_pkg::*;

   typedef struct {
      bit       id_valid;
      bit [4:0] rs1;
      bit [4:0] rs2;
      bit       rs1_used;
      bit       rs2_used;
      bit [4:0] rd;
      bit       rd_we;
      bit       ll_op;
      bit       ex_valid;
      bit [1:0] wb_sel;
      bit [4:0] ex_rd;
      bit       ex_we;
      bit       ll_issue;
      bit [4:0] ll_issue_rd;
      bit       ll_done;
      bit [4:0] ll_done_rd;
      bit       ll_busy;
      bit       bt;
   } in_t;

   typedef struct {
      in_t i;
      bit  hold;
      bit  bubble;
      bit  flush;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_ll_op;
   logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr, ex_rd_addr, ll_issue_rd, ll_done_rd;
   logic       ex_valid, ex_rd_we, ll_issue, ll_done, ll_busy, branch_taken;
   logic [1:0] ex_wb_sel;

   logic        pc_hold     [2];
   logic        ifid_hold   [2];
   logic        idex_bubble [2];
   logic        ifid_flush  [2];
   logic [1:0]  hdu_state   [2];
   logic [31:0] stall_cycles[2];

   int        n_checks = 0;
   int        n_err    = 0;
   int        m_rem [2];
   bit [31:0] m_cnt [2];
   bit        m_busy[32];

   always #5 clk = ~clk;

   hazard_unit #(.REG_ADDR_W(5), .NUM_REGS(32), .LOAD_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_ll_op(id_ll_op),
      .ex_valid(ex_valid), .ex_wb_sel(ex_wb_sel), .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we),
      .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd), .ll_done(ll_done), .ll_done_rd(ll_done_rd),
      .ll_busy(ll_busy), .branch_taken(branch_taken),
      .pc_hold(pc_hold[0]), .ifid_hold(ifid_hold[0]), .idex_bubble(idex_bubble[0]),
      .ifid_flush(ifid_flush[0]), .hdu_state(hdu_state[0]), .stall_cycles(stall_cycles[0])
   );

   hazard_unit #(.REG_ADDR_W(5), .NUM_REGS(32), .LOAD_LAT(3)) u_lat3 (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_ll_op(id_ll_op),
      .ex_valid(ex_valid), .ex_wb_sel(ex_wb_sel), .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we),
      .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd), .ll_done(ll_done), .ll_done_rd(ll_done_rd),
      .ll_busy(ll_busy), .branch_taken(branch_taken),
      .pc_hold(pc_hold[1]), .ifid_hold(ifid_hold[1]), .idex_bubble(idex_bubble[1]),
      .ifid_flush(ifid_flush[1]), .hdu_state(hdu_state[1]), .stall_cycles(stall_cycles[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic in_t nop();
      in_t v;
      v = '{default: 0};
      return v;
   endfunction

   function automatic in_t lu_vec(bit [4:0] ex_rd, bit [4:0] rs1, bit r1u, bit [4:0] rs2, bit r2u);
      in_t v;
      v          = nop();
      v.id_valid = 1'b1;
      v.rs1      = rs1;
      v.rs1_used = r1u;
      v.rs2      = rs2;
      v.rs2_used = r2u;
      v.ex_valid = 1'b1;
      v.wb_sel   = WB_LOAD;
      v.ex_rd    = ex_rd;
      v.ex_we    = 1'b1;
      return v;
   endfunction

   function automatic bit src_hit(bit used, bit [4:0] a, bit [4:0] d);
      return used && a != 0 && a == d;
   endfunction

   function automatic bit load_use(in_t v);
      return v.id_valid && v.ex_valid && v.ex_we && v.wb_sel == WB_LOAD && v.ex_rd != 0 &&
             (src_hit(v.rs1_used, v.rs1, v.ex_rd) || src_hit(v.rs2_used, v.rs2, v.ex_rd));
   endfunction

   function automatic bit sb_stall(in_t v);
`ifdef HAZARD_SCOREBOARD_EN
      return v.id_valid && ((v.rs1_used && v.rs1 != 0 && m_busy[v.rs1]) ||
                            (v.rs2_used && v.rs2 != 0 && m_busy[v.rs2]) ||
                            (v.rd_we && m_busy[v.rd]) || (v.ll_op && v.ll_busy));
`else
      return v.id_valid && v.ll_busy;
`endif
   endfunction

   function automatic bit exp_stall(int k, in_t v);
      if (rst)
         return 1'b0;
      return !v.bt && ((load_use(v) && m_rem[k] == 0) || m_rem[k] > 0 || sb_stall(v));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_rem[k] = 0;
         m_cnt[k] = '0;
      end
      for (int r = 0; r < 32; r++)
         m_busy[r] = 1'b0;
   endtask

   task automatic drive(input in_t v);
      id_valid     = v.id_valid;
      id_rs1_addr  = v.rs1;
      id_rs2_addr  = v.rs2;
      id_rs1_used  = v.rs1_used;
      id_rs2_used  = v.rs2_used;
      id_rd_addr   = v.rd;
      id_rd_we     = v.rd_we;
      id_ll_op     = v.ll_op;
      ex_valid     = v.ex_valid;
      ex_wb_sel    = v.wb_sel;
      ex_rd_addr   = v.ex_rd;
      ex_rd_we     = v.ex_we;
      ll_issue     = v.ll_issue;
      ll_issue_rd  = v.ll_issue_rd;
      ll_done      = v.ll_done;
      ll_done_rd   = v.ll_done_rd;
      ll_busy      = v.ll_busy;
      branch_taken = v.bt;
   endtask

   task automatic drive_check(input in_t v);
      bit s;
      drive(v);
      #1;
      if (rst)
         model_reset();
      for (int k = 0; k < 2; k++) begin
         s = exp_stall(k, v);
         chk($sformatf("pc_hold[%0d]", k), 32'(pc_hold[k]), 32'(s));
         chk($sformatf("ifid_hold[%0d]", k), 32'(ifid_hold[k]), 32'(s));
         chk($sformatf("idex_bubble[%0d]", k), 32'(idex_bubble[k]), 32'(!rst && (s || v.bt)));
         chk($sformatf("ifid_flush[%0d]", k), 32'(ifid_flush[k]), 32'(!rst && v.bt));
         chk($sformatf("hdu_state[%0d]", k), 32'(hdu_state[k]), (m_rem[k] > 0) ? 32'd1 : 32'd0);
         chk($sformatf("stall_cycles[%0d]", k), stall_cycles[k], m_cnt[k]);
      end
   endtask

   task automatic clk_update(input in_t v);
      bit s [2];
      for (int k = 0; k < 2; k++)
         s[k] = exp_stall(k, v);
      @(posedge clk);
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            m_cnt[k] = m_cnt[k] + 32'(s[k]);
            if (v.bt)
               m_rem[k] = 0;
            else if (m_rem[k] > 0)
               m_rem[k] = m_rem[k] - 1;
            else if (load_use(v))
               m_rem[k] = (k == 0) ? 0 : 2;
         end
         if (v.ll_done)
            m_busy[v.ll_done_rd] = 1'b0;
         if (v.ll_issue && v.ll_issue_rd != 0)
            m_busy[v.ll_issue_rd] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic step(input in_t v);
      in_t w;
      w = v;
      if (w.ll_issue && (exp_stall(0, w) || exp_stall(1, w)))
         w.ll_issue = 1'b0;
      drive_check(w);
      clk_update(w);
   endtask

   vec_t tbl [12];
   in_t  v, r;

   initial begin
      rst = 1'b1;
      model_reset();
      drive(nop());
      repeat (2) @(negedge clk);
      drive_check(nop());
      @(negedge clk);
      rst = 1'b0;

      // Load to x5 in EX, ID reads x5: LAT=1 stalls once, LAT=3 stalls three cycles.
      v = lu_vec(5, 5, 1, 0, 0);
      drive_check(v);
      chk("lu_hold_lat1", 32'(pc_hold[0]), 32'd1);
      chk("lu_hold_lat3", 32'(pc_hold[1]), 32'd1);
      chk("lu_bubble_lat1", 32'(idex_bubble[0]), 32'd1);
      chk("lu_state_c0", 32'(hdu_state[1]), 32'd0);
      clk_update(v);
      r = nop(); r.id_valid = 1; r.rs1 = 5; r.rs1_used = 1;
      drive_check(r);
      chk("lu_hold_lat1_c1", 32'(pc_hold[0]), 32'd0);
      chk("lu_hold_lat3_c1", 32'(pc_hold[1]), 32'd1);
      chk("lu_state_c1", 32'(hdu_state[1]), 32'd1);
      clk_update(r);
      drive_check(r);
      chk("lu_hold_lat3_c2", 32'(pc_hold[1]), 32'd1);
      chk("lu_state_c2", 32'(hdu_state[1]), 32'd1);
      clk_update(r);
      drive_check(r);
      chk("lu_hold_lat3_c3", 32'(pc_hold[1]), 32'd0);
      chk("lu_state_c3", 32'(hdu_state[1]), 32'd0);
      chk("lu_cnt_lat1", stall_cycles[0], 32'd1);
      chk("lu_cnt_lat3", stall_cycles[1], 32'd3);
      clk_update(r);

      // Single-cycle detection vectors, each applied from IDLE then drained.
      tbl[0]  = '{lu_vec(5, 5, 1, 0, 0), 1, 1, 0};
      tbl[1]  = '{lu_vec(0, 0, 1, 0, 1), 0, 0, 0};
      tbl[2]  = '{lu_vec(7, 3, 1, 7, 1), 1, 1, 0};
      tbl[3]  = '{lu_vec(7, 3, 1, 7, 0), 0, 0, 0};
      tbl[4]  = '{lu_vec(7, 7, 1, 0, 0), 0, 0, 0}; tbl[4].i.id_valid = 0;
      tbl[5]  = '{lu_vec(7, 7, 1, 0, 0), 0, 0, 0}; tbl[5].i.wb_sel = WB_ALU;
      tbl[6]  = '{lu_vec(7, 7, 1, 0, 0), 0, 0, 0}; tbl[6].i.ex_we = 0;
      tbl[7]  = '{lu_vec(7, 7, 1, 0, 0), 0, 0, 0}; tbl[7].i.ex_valid = 0;
      tbl[8]  = '{lu_vec(7, 7, 1, 0, 0), 0, 1, 1}; tbl[8].i.bt = 1;
      tbl[9]  = '{nop(), 0, 1, 1}; tbl[9].i.bt = 1;
      tbl[10] = '{nop(), 1, 1, 0}; tbl[10].i.id_valid = 1; tbl[10].i.ll_op = 1; tbl[10].i.ll_busy = 1;
      tbl[11] = '{nop(), 0, 0, 0}; tbl[11].i.ll_busy = 1;
      for (int i = 0; i < 12; i++) begin
         drive_check(tbl[i].i);
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("tbl%0d_hold[%0d]", i, k), 32'(pc_hold[k]), 32'(tbl[i].hold));
            chk($sformatf("tbl%0d_bubble[%0d]", i, k), 32'(idex_bubble[k]), 32'(tbl[i].bubble));
            chk($sformatf("tbl%0d_flush[%0d]", i, k), 32'(ifid_flush[k]), 32'(tbl[i].flush));
         end
         clk_update(tbl[i].i);
         repeat (3) step(nop());
      end

      // Taken branch in the second cycle of a 3-cycle load stall.
      v = lu_vec(7, 0, 0, 7, 1);
      drive_check(v);
      clk_update(v);
      r = nop(); r.id_valid = 1; r.rs2 = 7; r.rs2_used = 1; r.bt = 1;
      drive_check(r);
      chk("br_flush", 32'(ifid_flush[1]), 32'd1);
      chk("br_hold", 32'(pc_hold[1]), 32'd0);
      chk("br_bubble", 32'(idex_bubble[1]), 32'd1);
      clk_update(r);
      drive_check(nop());
      chk("br_state_after", 32'(hdu_state[1]), 32'd0);
      chk("br_hold_after", 32'(pc_hold[1]), 32'd0);
      clk_update(nop());

      // Reset asserted while LAT=3 instance is in LOAD_WAIT.
      v = lu_vec(5, 5, 1, 0, 0);
      drive_check(v);
      clk_update(v);
      rst = 1'b1;
      drive_check(v);
      chk("rst_hold", 32'(pc_hold[1]), 32'd0);
      chk("rst_state", 32'(hdu_state[1]), 32'd0);
      chk("rst_cnt", stall_cycles[1], 32'd0);
      clk_update(v);
      rst = 1'b0;
      r = nop(); r.id_valid = 1; r.rs1 = 5; r.rs1_used = 1;
      drive_check(r);
      chk("rst_release_hold", 32'(pc_hold[1]), 32'd0);
      clk_update(r);

`ifdef HAZARD_SCOREBOARD_EN
      // x9 busy until ll_done, release the cycle after; same-cycle issue/done keeps it busy.
      v = nop(); v.ll_issue = 1; v.ll_issue_rd = 9;
      step(v);
      r = nop(); r.id_valid = 1; r.rs1 = 9; r.rs1_used = 1;
      for (int c = 0; c < 3; c++) begin
         v = r;
         if (c == 2) begin v.ll_done = 1; v.ll_done_rd = 9; end
         drive_check(v);
         chk($sformatf("sb_hold_c%0d", c), 32'(pc_hold[0]), 32'd1);
         clk_update(v);
      end
      drive_check(r);
      chk("sb_release", 32'(pc_hold[0]), 32'd0);
      clk_update(r);
      v = nop(); v.ll_issue = 1; v.ll_issue_rd = 9;
      step(v);
      v.ll_done = 1; v.ll_done_rd = 9;
      step(v);
      drive_check(r);
      chk("sb_same_cycle_busy", 32'(pc_hold[0]), 32'd1);
      clk_update(r);
      v = nop(); v.ll_done = 1; v.ll_done_rd = 9;
      step(v);
      drive_check(r);
      chk("sb_final_release", 32'(pc_hold[0]), 32'd0);
      clk_update(r);
`else
      // ll_busy serialises ID regardless of registers.
      v = nop(); v.id_valid = 1; v.rs1 = 12; v.rs1_used = 1; v.ll_busy = 1;
      for (int c = 0; c < 4; c++) begin
         drive_check(v);
         chk($sformatf("busy_hold_c%0d", c), 32'(pc_hold[0]), 32'd1);
         clk_update(v);
      end
      v.ll_busy = 0;
      drive_check(v);
      chk("busy_release", 32'(pc_hold[0]), 32'd0);
      clk_update(v);
`endif

      for (int n = 0; n < 400; n++) begin
         v             = nop();
         v.id_valid    = $urandom_range(0, 3) != 0;
         v.rs1         = 5'($urandom_range(0, 7));
         v.rs2         = 5'($urandom_range(0, 7));
         v.rs1_used    = $urandom_range(0, 3) != 0;
         v.rs2_used    = $urandom_range(0, 1) != 0;
         v.rd          = 5'($urandom_range(0, 7));
         v.rd_we       = $urandom_range(0, 1) != 0;
         v.ll_op       = $urandom_range(0, 4) == 0;
         v.ex_valid    = $urandom_range(0, 3) != 0;
         v.wb_sel      = 2'($urandom_range(0, 3));
         v.ex_rd       = 5'($urandom_range(0, 7));
         v.ex_we       = $urandom_range(0, 3) != 0;
         v.ll_issue    = $urandom_range(0, 3) == 0;
         v.ll_issue_rd = 5'($urandom_range(0, 7));
         v.ll_done     = $urandom_range(0, 3) == 0;
         v.ll_done_rd  = 5'($urandom_range(0, 7));
         v.ll_busy     = $urandom_range(0, 4) == 0;
         v.bt          = $urandom_range(0, 9) == 0;
         step(v);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
